uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Frame-level scheduler that shares one `uart_transmitter` between `NREQ` requesters. Each requester presents a complete `FRAME_BYTES`-byte frame. The block grants whole frames round-robin, latches the winning frame, and feeds it byte by byte to the transmitter through the `tx_start`/`tx_done` handshake. It sits between the badge's frame sources (flag generator, status/button reporter) and `UART_TX_UNIT`, replacing the constant `tx_start`/`data_in` tie-offs.

## Interface
Parameters:
- `DBITS`, 8, bits per UART data byte; must match the transmitter.
- `FRAME_BYTES`, 4, bytes per frame; ≥1.
- `NREQ`, 2, number of requesters; ≥1.

Ports:
- `clk_100MHz`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester frame request; level, held until `gnt` seen.
- `frame_data`  in  NREQ*FRAME_BYTES*DBITS  requester i's frame at slice [i*FRAME_BYTES*DBITS +: FRAME_BYTES*DBITS]; byte 0 is the least-significant DBITS of the slice.
- `gnt`  out  NREQ  one-cycle one-hot pulse: frame of requester i latched.
- `done`  out  NREQ  one-cycle one-hot pulse: last byte of requester i's frame completed.
- `busy`  out  1  high from grant until return to IDLE.
- `tx_start`  out  1  one-cycle pulse to the transmitter, one per byte.
- `tx_data`  out  DBITS  byte to transmit; stable from `tx_start` until `tx_done`.
- `tx_done`  in  1  transmitter completion pulse, one cycle, end of stop bit.

## Operation
- All outputs are registered. Reset values: `gnt`=0, `done`=0, `busy`=0, `tx_start`=0, `tx_data`=0. Internal state: IDLE, byte index 0, round-robin pointer 0.
- FSM states:
  - IDLE: if `req`≠0, pick a winner by round-robin from the pointer, latch its frame slice, pulse `gnt[w]`, set `busy`, set index=0, go to START.
  - START: drive `tx_data`=byte[index], pulse `tx_start`, go to WAIT.
  - WAIT: on `tx_done`, if index==FRAME_BYTES-1, pulse `done[w]`, clear `busy`, set pointer=(w+1) mod NREQ, go to IDLE. Otherwise increment index and go to START.
- Round-robin: search starts at the pointer and wraps. After reset, requester 0 has priority. A requester continuously asserting `req` cannot starve the others.
- Bytes are sent in order byte 0 … byte FRAME_BYTES-1.
- Frame data is latched at grant. Later changes to `frame_data` or deassertion of `req` do not affect the frame in flight.
- `tx_done` is ignored in IDLE and START.
- `req` is ignored while `busy`. Pending requests are arbitrated in the first IDLE cycle.
- Index counter width is clog2(FRAME_BYTES), minimum 1. It must not wrap before FRAME_BYTES-1 is compared.
- Asserting `reset_n` low mid-frame immediately forces IDLE and all outputs to reset values. The partial frame is abandoned, no `done` is emitted, and the pointer returns to 0.

## Timing
- `req` high before clock edge E → `gnt` high in cycle E..E+1 → `tx_start` high in cycle E+1..E+2.
- `tx_done` seen at edge T, not the last byte → next `tx_start` pulse in cycle T+1..T+2. Inter-byte overhead is 2 clocks.
- Last byte: `done` pulses in cycle T..T+1, and the block is IDLE from T+1. A waiting request gets `gnt` in cycle T+1..T+2.
- Minimum frame duration is FRAME_BYTES × (transmitter byte time + 2) clocks.

## Structure
- Shared package `uart_pkg` holds `DBITS`, `FRAME_BYTES`, the FSM state encoding (IDLE/START/WAIT), and the clog2 helper. The transmitter and arbiter both use it.
- One sub-module, `rr_arbiter`, contains:
  - Inputs: `req`, `pointer`.
  - Combinational outputs: one-hot winner and winner index.
  - `NREQ` parameter.
- The FSM, frame latch, byte mux and pointer register stay in `uart_tx_arbiter`.

## Test plan
- Single request: NREQ=2, FRAME_BYTES=4, `req`=01, frame 0 = 0x44_33_22_11. Expect `gnt`=01 once; `tx_data` sequence 0x11, 0x22, 0x33, 0x44, each with one `tx_start`; `done`=01 after the 4th `tx_done`; `busy` then 0.
- Contention: `req`=11 held continuously. Expect grant order 0,1,0,1 across four frames, with no back-to-back grants to the same requester.
- Data latching: change `frame_data` and drop `req` one cycle after `gnt`. Expect the original 4 bytes sent unchanged.
- Spurious done: pulse `tx_done` in IDLE and in the START cycle. Expect no index advance, no `done`, and no extra `tx_start`.
- Mid-frame reset: assert `reset_n`=0 after byte 2's `tx_start`. Expect all outputs 0 within the reset cycle and no `done`. With `req`=11 after release, requester 0 is granted first.
- Edge sizes: NREQ=1, FRAME_BYTES=1. Expect `gnt` → `tx_start` → (tx_done) → `done` per frame, and back-to-back frames with a 2-cycle gap.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path: default byte/frame sizes,
// the frame-scheduler FSM encoding, and a width helper.
// No ports (package).
package uart_pkg;

  localparam int DBITS       = 8;
  localparam int FRAME_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } tx_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit so a
  // single-entry counter or pointer still has a real register.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: searches req starting at pointer and
// wrapping, returns the first asserted requester.
// Ports:
//   req        in   NREQ  request vector
//   pointer    in   PW    index with highest priority this round
//   win_onehot out  NREQ  one-hot winner (all zero when req is zero)
//   win_idx    out  PW    winner index (zero when req is zero)
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int PW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   pointer,
  output logic [NREQ-1:0] win_onehot,
  output logic [PW-1:0]   win_idx
);

  int   cand;
  logic found;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    cand       = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(pointer) + k) % NREQ;
      if (!found && req[cand]) begin
        found            = 1'b1;
        win_onehot[cand] = 1'b1;
        win_idx          = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NREQ frame sources. Whole frames are
// granted round-robin, latched, and sent byte 0 first via tx_start/tx_done.
// Ports:
//   clk_100MHz  in   1                      system clock
//   reset_n     in   1                      async active-low reset
//   req         in   NREQ                   frame request (level)
//   frame_data  in   NREQ*FRAME_BYTES*DBITS frames, requester i at slice i
//   gnt         out  NREQ                   one-cycle pulse, frame latched
//   done        out  NREQ                   one-cycle pulse, frame finished
//   busy        out  1                      grant through return to IDLE
//   tx_start    out  1                      one-cycle pulse per byte
//   tx_data     out  DBITS                  byte held until tx_done
//   tx_done     in   1                      transmitter byte complete
//
// state    | meaning
// ST_IDLE  | no frame in flight; arbitrate pending requests
// ST_START | present byte[idx] and pulse tx_start
// ST_WAIT  | byte on the wire; wait for tx_done
module uart_tx_arbiter #(
  parameter int DBITS       = uart_pkg::DBITS,
  parameter int FRAME_BYTES = uart_pkg::FRAME_BYTES,
  parameter int NREQ        = 2
) (
  input  logic                               clk_100MHz,
  input  logic                               reset_n,
  input  logic [NREQ-1:0]                    req,
  input  logic [NREQ*FRAME_BYTES*DBITS-1:0]  frame_data,
  output logic [NREQ-1:0]                    gnt,
  output logic [NREQ-1:0]                    done,
  output logic                               busy,
  output logic                               tx_start,
  output logic [DBITS-1:0]                   tx_data,
  input  logic                               tx_done
);

  import uart_pkg::*;

  localparam int FW = FRAME_BYTES * DBITS;
  localparam int IW = clog2_min1(FRAME_BYTES);
  localparam int PW = clog2_min1(NREQ);

  tx_state_t         state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     sel_q, sel_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [NREQ-1:0]   gnt_d, done_d;
  logic              busy_d, tx_start_d;
  logic [DBITS-1:0]  tx_data_d;

  logic [NREQ-1:0]   win_onehot;
  logic [PW-1:0]     win_idx;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req),
    .pointer    (ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    frame_d    = frame_q;
    gnt_d      = '0;
    done_d     = '0;
    busy_d     = busy;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          frame_d = frame_data[win_idx*FW +: FW];
          gnt_d   = win_onehot;
          sel_d   = win_idx;
          busy_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_data_d  = frame_q[idx_q*DBITS +: DBITS];
        tx_start_d = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (idx_q == IW'(FRAME_BYTES - 1)) begin
            done_d  = NREQ'(1) << sel_q;
            busy_d  = 1'b0;
            // Next search starts just past the requester that was served.
            if (sel_q == PW'(NREQ - 1)) ptr_d = '0;
            else                        ptr_d = sel_q + 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_START;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      ptr_q    <= '0;
      sel_q    <= '0;
      frame_q  <= '0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      frame_q  <= frame_d;
      gnt      <= gnt_d;
      done     <= done_d;
      busy     <= busy_d;
      tx_start <= tx_start_d;
      tx_data  <= tx_data_d;
    end
  end

endmodule
